// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_access_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_RW       = 2'b11;

    // Classify a requested access; ERR_NONE means legal (or no access at all).
    // A simultaneous read+write is reported ahead of misalignment.
    function automatic logic [1:0] classify_access(input logic       rd,
                                                   input logic       wr,
                                                   input logic [1:0] addr_lo);
        logic [1:0] cause;
        cause = ERR_NONE;
        if (rd && wr) begin
            cause = ERR_RW;
        end else if ((rd || wr) && (addr_lo != 2'b00)) begin
            cause = ERR_MISALIGN;
        end
        return cause;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter for the BUSY state; expired_o flags the last allowed cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    logic [7:0] count_q, count_d;

    // Clear wins over enable so a fresh access always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access controller: issues req/ack bus transactions for
// loads/stores, stalls the upstream pipeline while one is outstanding, and
// flags misaligned, conflicting or timed-out accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] ALU_result_MEM,
    input  logic [WORD_W-1:0] Read_Data_2_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              Branch_MEM,
    input  logic              Zero_MEM,
    input  logic              Jump_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] Read_data_MEM,
    output logic              pc_redirect,
    output logic              mem_error,
    output logic [1:0]        err_cause
);

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [WORD_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              mem_error_q;
    logic [1:0]        err_cause_q;

    logic       access;
    logic [1:0] acc_cause;
    logic       legal_access;
    logic       illegal_access;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;

    // Decode the EX/MEM request presented this cycle.
    always_comb begin
        access         = MemRead_MEM | MemWrite_MEM;
        acc_cause      = classify_access(MemRead_MEM, MemWrite_MEM, ALU_result_MEM[1:0]);
        legal_access   = access && (acc_cause == ERR_NONE);
        illegal_access = (acc_cause != ERR_NONE);
    end

    // Counter runs only while waiting for ack; it restarts from zero otherwise.
    always_comb begin
        timer_clr = (state_q != StBusy);
        timer_en  = (state_q == StBusy) && !mem_ack;
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Controller FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_error_q <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (legal_access) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= MemWrite_MEM;
                        mem_addr_q  <= ALU_result_MEM;
                        mem_wdata_q <= Read_Data_2_MEM;
                        state_q     <= StBusy;
                    end else if (illegal_access) begin
                        // Illegal accesses never reach the bus; only the first cause sticks.
                        rdata_q     <= '0;
                        mem_error_q <= 1'b1;
                        if (!mem_error_q) begin
                            err_cause_q <= acc_cause;
                        end
                    end
                end
                StBusy: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= StDone;
                    end else if (timer_expired) begin
                        mem_req_q   <= 1'b0;
                        rdata_q     <= '0;
                        mem_error_q <= 1'b1;
                        if (!mem_error_q) begin
                            err_cause_q <= ERR_TIMEOUT;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // EX/MEM advances on this edge, so the completed access is not re-issued.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall is gated by reset so an abandoned transaction releases the pipeline at once.
    always_comb begin
        stall       = rst_n && (((state_q == StIdle) && legal_access) || (state_q == StBusy));
        wb_valid    = !stall;
        pc_redirect = (Branch_MEM & Zero_MEM) | Jump_MEM;
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign Read_data_MEM = rdata_q;
    assign mem_error     = mem_error_q;
    assign err_cause     = err_cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 8).
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALU_result_MEM;
    logic [31:0] Read_Data_2_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic        Branch_MEM;
    logic        Zero_MEM;
    logic        Jump_MEM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] Read_data_MEM;
    logic        pc_redirect;
    logic        mem_error;
    logic [1:0]  err_cause;

    int n_checks;
    int n_errors;

    mem_access_unit #(
        .TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ALU_result_MEM  (ALU_result_MEM),
        .Read_Data_2_MEM (Read_Data_2_MEM),
        .MemRead_MEM     (MemRead_MEM),
        .MemWrite_MEM    (MemWrite_MEM),
        .Branch_MEM      (Branch_MEM),
        .Zero_MEM        (Zero_MEM),
        .Jump_MEM        (Jump_MEM),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .wb_valid        (wb_valid),
        .Read_data_MEM   (Read_data_MEM),
        .pc_redirect     (pc_redirect),
        .mem_error       (mem_error),
        .err_cause       (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ALU_result_MEM  = 32'h0;
        Read_Data_2_MEM = 32'h0;
        MemRead_MEM     = 1'b0;
        MemWrite_MEM    = 1'b0;
        Branch_MEM      = 1'b0;
        Zero_MEM        = 1'b0;
        Jump_MEM        = 1'b0;
        mem_ack         = 1'b0;
        mem_rdata       = 32'h0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        n_checks++;
        if ({mem_req, mem_we, stall, mem_error} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got req/we/stall/err=%b expected 0000",
                     {mem_req, mem_we, stall, mem_error});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, Read_data_MEM} !== 96'h0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected all 0",
                     mem_addr, mem_wdata, Read_data_MEM);
        end
        n_checks++;
        if (err_cause !== 2'b00 || wb_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_cause_wb: got cause=%b wb_valid=%b expected 00 1",
                     err_cause, wb_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        next_cycle();
        MemRead_MEM    = 1'b1;
        ALU_result_MEM = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL load_idle: got stall=%b req=%b wb=%b expected 1 0 0",
                     stall, mem_req, wb_valid);
        end
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1) begin
            n_errors++;
            $display("FAIL load_busy: got req=%b we=%b addr=%h stall=%b expected 1 0 100 1",
                     mem_req, mem_we, mem_addr, stall);
        end
        next_cycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || wb_valid !== 1'b1 || mem_req !== 1'b0 ||
            Read_data_MEM !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL load_done: got stall=%b wb=%b req=%b rdata=%h expected 0 1 0 deadbeef",
                     stall, wb_valid, mem_req, Read_data_MEM);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL load_no_reissue: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
    endtask

    task automatic test_store();
        int stall_cnt;
        stall_cnt = 0;
        next_cycle();
        MemWrite_MEM    = 1'b1;
        ALU_result_MEM  = 32'h0000_0204;
        Read_Data_2_MEM = 32'h1234_5678;
        @(negedge clk);
        if (stall === 1'b1) stall_cnt++;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            // Perturb the inputs: the bus side must hold its latched values.
            ALU_result_MEM  = 32'h0;
            Read_Data_2_MEM = 32'hFFFF_FFFF;
            mem_ack         = (i == 4);
            mem_rdata       = 32'h5555_5555;
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204 ||
                mem_wdata !== 32'h1234_5678) begin
                n_errors++;
                $display("FAIL store_busy[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1 1 204 12345678",
                         i, mem_req, mem_we, mem_addr, mem_wdata);
            end
        end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        if (stall === 1'b1) stall_cnt++;
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || Read_data_MEM !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL store_done: got stall=%b req=%b rdata=%h expected 0 0 deadbeef",
                     stall, mem_req, Read_data_MEM);
        end
        n_checks++;
        if (stall_cnt !== 6) begin
            n_errors++;
            $display("FAIL store_stall_cycles: got %0d expected 6", stall_cnt);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_jump();
        next_cycle();
        Branch_MEM = 1'b1;
        Zero_MEM   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc_redirect !== 1'b1 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_taken: got redirect=%b stall=%b expected 1 0", pc_redirect, stall);
        end
        next_cycle();
        Zero_MEM = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_redirect !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_not_taken: got redirect=%b stall=%b expected 0 0", pc_redirect, stall);
        end
        next_cycle();
        Branch_MEM = 1'b0;
        Jump_MEM   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc_redirect !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL jump: got redirect=%b stall=%b req=%b expected 1 0 0",
                     pc_redirect, stall, mem_req);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_misaligned();
        next_cycle();
        MemRead_MEM    = 1'b1;
        ALU_result_MEM = 32'h0000_0103;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL misalign_issue: got stall=%b req=%b wb=%b expected 0 0 1",
                     stall, mem_req, wb_valid);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (mem_error !== 1'b1 || err_cause !== 2'b01 || Read_data_MEM !== 32'h0 ||
            mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL misalign_error: got err=%b cause=%b rdata=%h req=%b expected 1 01 0 0",
                     mem_error, err_cause, Read_data_MEM, mem_req);
        end
    endtask

    task automatic test_timeout(input logic [1:0] exp_cause);
        int busy_cycles;
        bit dropped;
        busy_cycles = 0;
        dropped     = 1'b0;
        next_cycle();
        MemRead_MEM    = 1'b1;
        ALU_result_MEM = 32'h0000_0300;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_issue: got stall=%b expected 1", stall);
        end
        for (int i = 0; i < 20 && !dropped; i++) begin
            next_cycle();
            @(negedge clk);
            if (mem_req === 1'b1) busy_cycles++;
            else dropped = 1'b1;
        end
        n_checks++;
        if (busy_cycles !== 8) begin
            n_errors++;
            $display("FAIL timeout_busy_cycles: got %0d expected 8", busy_cycles);
        end
        n_checks++;
        if (stall !== 1'b0 || Read_data_MEM !== 32'h0 || mem_error !== 1'b1 ||
            err_cause !== exp_cause) begin
            n_errors++;
            $display("FAIL timeout_done: got stall=%b rdata=%h err=%b cause=%b expected 0 0 1 %b",
                     stall, Read_data_MEM, mem_error, err_cause, exp_cause);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_idle: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
    endtask

    task automatic test_reset_in_busy();
        next_cycle();
        MemRead_MEM    = 1'b1;
        ALU_result_MEM = 32'h0000_0400;
        next_cycle();
        next_cycle();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_busy_pre: got req=%b expected 1", mem_req);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || mem_error !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_busy_immediate: got req=%b stall=%b err=%b expected 0 0 0",
                     mem_req, stall, mem_error);
        end
        MemRead_MEM = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_late_ack: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (Read_data_MEM !== 32'h0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_ack_ignored: got rdata=%h req=%b expected 0 0", Read_data_MEM, mem_req);
        end
    endtask

    task automatic test_rw_conflict();
        next_cycle();
        MemRead_MEM    = 1'b1;
        MemWrite_MEM   = 1'b1;
        ALU_result_MEM = 32'h0000_0500;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rw_issue: got stall=%b req=%b expected 0 0", stall, mem_req);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (mem_error !== 1'b1 || err_cause !== 2'b11 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rw_error: got err=%b cause=%b req=%b expected 1 11 0",
                     mem_error, err_cause, mem_req);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_load();
        test_store();
        test_branch_jump();
        test_timeout(2'b10);
        test_reset();
        test_load();
        test_misaligned();
        test_timeout(2'b01);
        test_reset_in_busy();
        test_rw_conflict();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage memory access controller of the 5-stage MIPS pipeline. It sits downstream of the EX/MEM pipeline register and consumes that register's outputs. It turns load and store requests into a request/acknowledge transaction on the data-memory bus and stalls the upstream pipeline while a transaction is outstanding. It also delivers load data and the branch/jump redirect to the MEM/WB side.

## Interface
- `TIMEOUT`, default 255: BUSY cycles without `mem_ack` before the access is abandoned (1..255).
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ALU_result_MEM` in 32: effective address.
- `Read_Data_2_MEM` in 32: store data.
- `MemRead_MEM`, `MemWrite_MEM`, `Branch_MEM`, `Zero_MEM`, `Jump_MEM` in 1 each: control from EX/MEM.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: 1 = write, registered.
- `mem_addr` out 32: registered address.
- `mem_wdata` out 32: registered store data.
- `mem_ack` in 1: one-cycle completion pulse from memory.
- `mem_rdata` in 32: read data, valid in the cycle `mem_ack` is high.
- `stall` out 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `wb_valid` out 1: MEM/WB captures a real instruction; 0 = insert bubble. Equals `!stall`.
- `Read_data_MEM` out 32: registered load data.
- `pc_redirect` out 1: `(Branch_MEM & Zero_MEM) | Jump_MEM`, combinational.
- `mem_error` out 1: sticky error flag.
- `err_cause` out 2: first error seen; 01 misaligned, 10 timeout, 11 read+write together.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - Access = `MemRead_MEM | MemWrite_MEM`.
  - On a legal access: `stall`=1. On the edge, latch `mem_addr`/`mem_wdata`/`mem_we`, set `mem_req`=1, clear the wait counter and go to BUSY.
  - No access: `stall`=0 and the state stays IDLE.
  - Illegal access means `ALU_result_MEM[1:0]`≠0, or both `MemRead_MEM` and `MemWrite_MEM` set.
    - No bus transaction is started and `stall`=0.
    - `Read_data_MEM` is loaded with 0.
    - `mem_error` is set. `err_cause` is loaded only if `mem_error` was 0.
- **BUSY**
  - `stall`=1 and `mem_req` is held high.
  - When `mem_ack`=1 at an edge:
    - Clear `mem_req`.
    - On a read, `Read_data_MEM`←`mem_rdata`; a write leaves `Read_data_MEM` unchanged.
    - Go to DONE.
  - Otherwise the counter increments. When counter = TIMEOUT−1 without ack:
    - Clear `mem_req` and set `Read_data_MEM`←0.
    - Set the error with cause 10 under the same first-error rule.
    - Go to DONE.
- **DONE**
  - `stall`=0 and no new access is issued.
  - The EX/MEM register advances at this edge. The FSM returns to IDLE unconditionally.
  - This prevents re-issuing the access for the instruction that just completed.
- `mem_ack` outside BUSY is ignored.
- `mem_error`/`err_cause` clear only on reset.

## Timing
- Reset (async, immediate): state IDLE; `mem_req`, `mem_we`, `stall`, `mem_error` = 0; `mem_addr`, `mem_wdata`, `Read_data_MEM`, counter = 0; `err_cause` = 00.
  - `pc_redirect` and `wb_valid` follow their combinational inputs.
  - Reset in BUSY drops `mem_req` at once; the outstanding transaction is abandoned.
- `stall` is combinational from state and inputs: `(IDLE & legal access) | BUSY`.
- Minimum access with ack in the first BUSY cycle:
  - IDLE (stall) → BUSY (stall, ack) → DONE (no stall).
  - That is 2 stall cycles; `Read_data_MEM` is valid throughout DONE.
- Each extra wait cycle adds one stall cycle.
- Non-memory instructions, including branch and jump, pass with zero stall.
- `pc_redirect` has zero latency.

## Structure
- Package `mem_access_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - the `err_cause` constants (`ERR_NONE`, `ERR_MISALIGN`, `ERR_TIMEOUT`, `ERR_RW`);
  - the 32-bit word width constant.
- One sub-module, `mem_wait_timer`: 8-bit counter with clear, enable and an `expired` output (count = TIMEOUT−1).

## Test plan
- Load, addr 0x100, ack on 1st BUSY cycle, rdata 0xDEADBEEF:
  - `mem_req` high for 1 cycle, `mem_we`=0, `stall` high 2 cycles.
  - `Read_data_MEM`=0xDEADBEEF and `wb_valid`=1 in DONE.
- Store, addr 0x204, data 0x12345678, ack after 4 wait cycles:
  - `mem_we`=1 and `mem_addr`/`mem_wdata` stable while `mem_req` is high.
  - `stall` high for 6 cycles.
- Load, addr 0x103:
  - no `mem_req`, `stall`=0.
  - `mem_error`=1, `err_cause`=01, `Read_data_MEM`=0.
  - A subsequent timeout leaves `err_cause`=01.
- Load with no ack, TIMEOUT=8:
  - `mem_req` drops after 8 BUSY cycles.
  - `err_cause`=10, `Read_data_MEM`=0, then DONE.
- Reset asserted in the 2nd BUSY cycle:
  - `mem_req` and `stall` go to 0 immediately.
  - State is IDLE after release; a late `mem_ack` is ignored.
- `Branch_MEM`=1 with `Zero_MEM`=1, then `Branch_MEM`=1 with `Zero_MEM`=0, then `Jump_MEM`=1:
  - `pc_redirect` = 1, 0, 1 in the same cycles, with no stall.
